window3x3_gen: RTL and testbench

//  Streaming 3x3 neighbourhood generator feeding the morphological/convolution filters (Erosion etc.).

---
 rtl/window3x3_gen_if.sv | 30 +++
 rtl/window3x3_gen.sv | 147 ++++++++++++++
 tb/tb_window3x3_gen.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window3x3_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : window3x3_gen_if
// Purpose  : Pixel-in / window-out stream bundle for the 3x3 window generator.
//            The slave view belongs to the generator, the master view to the
//            pixel source and the window consumer.
// Revision : 1.0  initial release
// ============================================================================
interface window3x3_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [9*DATA_W-1:0] out_window;
  logic                out_valid;
  logic                out_ready;
  logic                frame_done;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_window, out_valid, frame_done
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_window, out_valid, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/window3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : window3x3_gen
// Purpose  : Streaming 3x3 neighbourhood generator. Buffers two raster lines
//            and emits one packed window per interior pixel, slot k = 3*row+col
//            at [DATA_W*k +: DATA_W], row 0 = top, col 0 = left.
// Revision : 1.0  initial release
// ============================================================================
module window3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  window3x3_gen_if.slave    bus
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  // Line buffers: lb1 holds line y-1, lb2 holds line y-2 (at columns not yet
  // overwritten in the current line).
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb2 [IMG_WIDTH];

  // Previous two columns of the window: index 0 = column x-1, 1 = column x-2.
  logic [DATA_W-1:0] top0, top1, mid0, mid1, bot0, bot1;

  logic                out_valid;
  logic [9*DATA_W-1:0] out_window;
  logic                frame_done;

  logic                in_ready;
  logic                xfer;
  logic                emit;
  logic                out_xfer;
  logic [DATA_W-1:0]   pix;
  logic [DATA_W-1:0]   lb_top;
  logic [DATA_W-1:0]   lb_mid;
  logic [9*DATA_W-1:0] new_window;

  assign pix    = bus.in_data;
  assign lb_top = lb2[x];
  assign lb_mid = lb1[x];

  // Input is refused while draining or while a held window would be lost.
  assign in_ready = !rst && (state != DRAIN) && (!out_valid || bus.out_ready);
  assign xfer     = bus.in_valid && in_ready;
  assign out_xfer = out_valid && bus.out_ready;
  assign emit     = xfer && (state == RUN) && (x >= X_TWO) && (y >= Y_TWO);

  // Newest column (x) comes straight from the line buffers and the input.
  assign new_window = {pix,    bot0, bot1,
                       lb_mid, mid0, mid1,
                       lb_top, top0, top1};

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_window = out_window;
  assign bus.frame_done = frame_done;

  // Line-buffer rotation and column shift on every accepted pixel.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb2[x] <= lb_mid;
      lb1[x] <= pix;
      top1   <= top0;
      top0   <= lb_top;
      mid1   <= mid0;
      mid0   <= lb_mid;
      bot1   <= bot0;
      bot0   <= pix;
    end
  end

  // Raster counters, frame FSM and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      x          <= '0;
      y          <= '0;
      out_valid  <= 1'b0;
      out_window <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (emit) begin
        out_valid  <= 1'b1;
        out_window <= new_window;
      end

      if (xfer) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end

      case (state)
        FILL: begin
          if (xfer && (x == X_LAST) && (y == Y_ONE)) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (xfer && (x == X_LAST) && (y == Y_LAST)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Pulse is raised while still in DRAIN so it never overlaps in_ready.
          if (frame_done) begin
            state <= FILL;
          end else if (out_xfer) begin
            frame_done <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window3x3_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_window3x3_gen
// Purpose  : Self-checking bench for window3x3_gen on a 4x4 image. A driver
//            sends frames and queues the windows expected from an image array;
//            an independent monitor compares every accepted window.
// Revision : 1.0  initial release
// ============================================================================
module tb_window3x3_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  localparam logic [71:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] HOLE_WIN  = 72'h80_80_80_80_00_80_80_80_80;

  logic clk = 1'b0;
  logic rst = 1'b1;

  window3x3_gen_if #(.DATA_W(DW)) bus ();

  window3x3_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_W    (DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int passes   = 0;
  int fd_count = 0;
  int gap_pct  = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by the test

  logic [71:0] exp_q [$];
  logic [71:0] seen  [$];
  logic [7:0]  img   [H][W];

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference window straight from the image: row r, column c of the
  // neighbourhood whose bottom-right pixel is (px,py).
  function automatic logic [71:0] model_window(input int px, input int py);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[8*(3*r+c) +: 8] = img[py-2+r][px-2+c];
    return w;
  endfunction

  task automatic fill_img(input int kind);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        case (kind)
          0: img[yy][xx] = 8'(16*yy + xx);
          1: img[yy][xx] = 8'(255 - (16*yy + xx));
          2: img[yy][xx] = (xx == 1 && yy == 1) ? 8'h00 : 8'h80;
          default: img[yy][xx] = 8'($urandom);
        endcase
  endtask

  task automatic send_pixel(input int px, input int py, input bit lat);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
      bus.in_data  = img[py][px];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        done = 1'b1;
      end else begin
        n++;
        if (n > 2000) begin
          checks++;
          $display("FAIL in_ready_timeout: pixel (%0d,%0d) never accepted", px, py);
          return;
        end
      end
    end
    if (px >= 2 && py >= 2) exp_q.push_back(model_window(px, py));
    if (lat) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("latency_out_valid", 72'(bus.out_valid), 72'd1);
    end
  endtask

  task automatic send_frame(input int kind, input bit lat);
    fill_img(kind);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        send_pixel(xx, yy, lat && xx == 2 && yy == 2);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int fd_target);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fd_count < fd_target) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("frame_done_count", 72'(fd_count), 72'(fd_target));
    check("queue_empty", 72'(exp_q.size()), 72'd0);
  endtask

  // Output-ready driver.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) bus.out_ready = 1'b1;
      else if (rdy_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: scoreboard compare, hold stability, frame_done behaviour.
  logic        stall;
  logic [71:0] stall_win;
  initial begin
    stall     = 1'b0;
    stall_win = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 72'(bus.out_valid), 72'd1);
          check("hold_window", bus.out_window, stall_win);
        end
        if (bus.frame_done) begin
          fd_count++;
          check("frame_done_in_ready", 72'(bus.in_ready), 72'd0);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_window: got %h expected none", bus.out_window);
          end else begin
            check("window", bus.out_window, exp_q.pop_front());
          end
          seen.push_back(bus.out_window);
        end
        stall     = bus.out_valid && !bus.out_ready;
        stall_win = bus.out_window;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Test sequence.
  initial begin
    int          base;
    int          n;
    bit          stable;
    logic [71:0] win;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", 72'(bus.out_valid), 72'd0);
    check("rst_out_window", bus.out_window, 72'd0);
    check("rst_frame_done", 72'(bus.frame_done), 72'd0);
    check("rst_in_ready", 72'(bus.in_ready), 72'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 72'(bus.in_ready), 72'd1);

    // 1: full frame, always ready.
    base = seen.size();
    send_frame(0, 1'b1);
    wait_idle(1);
    check("t1_count", 72'(seen.size() - base), 72'd4);
    check("t1_first", seen[base], FIRST_WIN);
    check("t1_last_centre", 72'(seen[base+3][39:32]), 72'h22);

    // 2: consumer stalls after first window.
    rdy_mode = 2;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    base = seen.size();
    fork
      send_frame(0, 1'b0);
      begin
        n = 0;
        while (!bus.out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("t2_in_ready_stall", 72'(bus.in_ready), 72'd0);
        win    = bus.out_window;
        stable = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (bus.out_window !== win || !bus.out_valid || bus.in_ready) stable = 1'b0;
        end
        check("t2_hold20_stable", 72'(stable), 72'd1);
        check("t2_held_window", win, FIRST_WIN);
        @(posedge clk); #1;
        rdy_mode      = 0;
        bus.out_ready = 1'b1;
      end
    join
    wait_idle(2);
    check("t2_count", 72'(seen.size() - base), 72'd4);

    // 3: random input gaps and random output ready.
    gap_pct  = 50;
    rdy_mode = 1;
    base     = seen.size();
    send_frame(0, 1'b0);
    wait_idle(3);
    check("t3_count", 72'(seen.size() - base), 72'd4);
    check("t3_first", seen[base], FIRST_WIN);

    // 4: reset after nine pixels, then a fresh inverted frame.
    gap_pct  = 0;
    rdy_mode = 0;
    fill_img(0);
    for (int i = 0; i < 9; i++) send_pixel(i % W, i / W, 1'b0);
    @(posedge clk); #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t4_rst_in_ready", 72'(bus.in_ready), 72'd0);
    check("t4_rst_out_valid", 72'(bus.out_valid), 72'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst  = 1'b0;
    base = seen.size();
    send_frame(1, 1'b0);
    wait_idle(4);
    check("t4_count", 72'(seen.size() - base), 72'd4);
    check("t4_first_slot0", 72'(seen[base][7:0]), 72'hFF);

    // 5: two back-to-back frames.
    base = seen.size();
    send_frame(0, 1'b0);
    send_frame(2, 1'b0);
    wait_idle(6);
    check("t5_count", 72'(seen.size() - base), 72'd8);
    check("t5_hole_window", seen[base+4], HOLE_WIN);

    // Random pixel frames under random flow control.
    gap_pct  = 30;
    rdy_mode = 1;
    base     = seen.size();
    for (int f = 0; f < 5; f++) send_frame(3, 1'b0);
    wait_idle(11);
    check("t6_count", 72'(seen.size() - base), 72'd20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
